reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer sitting directly downstream of the result queue. It allocates one entry per dispatched instruction and marks entries complete from the result queue's `complete_info` stream. It retires entries strictly in program order to the register-file write side. On retiring a mispredicted branch it discards all younger entries and raises a flush pulse.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `TAG_W`, `$clog2(DEPTH)`: derived; width of an entry tag.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `flash`  in  1  synchronous pipeline flush; empties the buffer at the edge.
- `alloc`  Message #(AllocReq) receiver  —  `msg = {dest[4:0], is_branch}`; this block drives `reject`.
- `alloc_tag`  out  TAG_W  tag assigned to the `alloc` request of this cycle; equals the tail index, combinational.
- `complete_info`  Message #(Result) receiver  —  `msg = {tag[TAG_W-1:0], data[31:0], mispredict}`; this block drives `reject` tied to 0.
- `commit`  Message #(Commit) sender  —  `msg = {dest[4:0], data[31:0]}`; the consumer drives `reject`.
- `mispredict_flash`  out  1  one-cycle pulse, the cycle after a mispredicted entry retires.

## Operation
- **Transfer rule:** a transfer occurs on any Message when `en && !reject` at the rising edge.
- **Entry state:** each entry is EMPTY, WAITING or DONE, and also holds `dest`, `data` and `mispredict`.
- **Pointers:** `head` and `tail` are TAG_W+1 bits; the MSB is a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- **Alloc:**
  - `alloc.reject = full`.
  - On transfer, `entry[tail]` becomes WAITING with `dest`, and `tail` increments (wrap DEPTH-1→0 toggles the MSB).
- **Complete:**
  - When `complete_info.en` and `entry[tag]` is WAITING: the entry becomes DONE and latches `data` and `mispredict`.
  - A tag whose entry is EMPTY or DONE is ignored with no state change.
- **Commit:**
  - `commit.en = !empty && entry[head]==DONE`.
  - `commit.msg` is taken from `entry[head]`.
  - On transfer, the entry becomes EMPTY and `head` increments.
- **Mispredict retire:** on a commit transfer of an entry with `mispredict=1`, at the same edge:
  - every entry becomes EMPTY;
  - `tail` is set to the new `head`;
  - any same-cycle alloc is discarded (its tag is dead);
  - `mispredict_flash` is registered to 1 for the following cycle only.
- **flash:** at the edge, all entries become EMPTY and `tail = head`. This overrides alloc, complete and commit in that cycle; no commit transfer counts.
- **Priority (highest first):** `reset` > `flash` > mispredict retire > normal alloc/complete/commit.

## Timing
- **Reset values:**
  - `head = tail = 0`; all entries EMPTY.
  - `commit.en = 0`, `alloc.reject = 0`, `alloc_tag = 0`, `mispredict_flash = 0`.
  - `complete_info.reject = 0` always.
- **Latency:**
  - Completion edge → `commit.en` high the next cycle, at minimum.
  - Alloc → earliest commit is 2 edges later (alloc edge, complete edge, then the commit-transfer edge).
- **Same-cycle interactions:**
  - A completion to the head entry is not visible to commit in the same cycle (no bypass).
  - Alloc and commit may both transfer in one cycle. When full, `alloc.reject` stays 1 even if a commit frees a slot that cycle.
  - A completion and an alloc to the same index in one cycle cannot occur: the index is EMPTY, so the completion is ignored.
- **Backpressure:** `commit.reject` held high stalls retirement; `commit.msg` must stay stable while `en` is held.
- **Reset mid-operation:** all in-flight entries are lost, and outputs take reset values asynchronously.

## Structure
- **typedefs.svh:** `AllocReq`, `Result` (shared with the result queue), `Commit`, and enum `RobState {EMPTY, WAITING, DONE}`.
- **Handshake:** use the existing `Message` interface from `bus.svh`.
- **Sub-module `rob_storage`:** DEPTH-entry array with one write port for alloc, one for complete, one read port at head, and a clear-all input. Pointer, flush and handshake logic stay in `reorder_buffer`.

## Test plan
- **Single instruction:** alloc `dest=3` (tag 0); complete `{0, 0xDEAD_BEEF, 0}` → next cycle `commit.en=1`, `msg={3, 0xDEADBEEF}`; buffer empty afterwards.
- **Out-of-order completion:** alloc tags 0, 1, 2; complete 2, 1, 0 → commits emitted in order 0, 1, 2, with `commit.en` first high the cycle after tag 0 completes.
- **Full and wrap:** alloc 16 → `alloc.reject=1`; retire one → reject drops; next `alloc_tag=0` with the MSB toggled; completion and commit still correct.
- **Mispredict:** alloc tags 0–3; complete 1, 2, 3 normally and tag 0 with `mispredict=1` → only tag 0 commits; `mispredict_flash=1` for exactly one cycle; buffer empty; next `alloc_tag=1`.
- **Backpressure and stray completion:** hold `commit.reject=1` for 3 cycles → `msg` stable, `head` unchanged. Complete an EMPTY tag → no commit, no state change.
- **flash and reset:** `flash` with 5 entries live → empty next cycle; `reset` asserted mid-commit → outputs at reset values asynchronously.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: message payloads and per-entry state.
package reorder_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      WAITING = 2'd1,
      DONE    = 2'd2
   } rob_state_t;

   typedef struct packed {
      logic [4:0] dest;
      logic       is_branch;
   } alloc_req_t;

   // Result payload; the tag travels alongside on its own TAG_W-wide port.
   typedef struct packed {
      logic [31:0] data;
      logic        mispredict;
   } result_t;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } commit_t;

   typedef struct packed {
      rob_state_t  state;
      logic [4:0]  dest;
      logic [31:0] data;
      logic        mispredict;
   } rob_entry_t;

endpackage

// File: rtl/rob_storage.sv
// Entry array: alloc write port, completion write port, head read port, clear-all.
module rob_storage
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             alloc_we,
   input  logic [TAG_W-1:0] alloc_idx,
   input  logic [4:0]       alloc_dest,
   input  logic             comp_we,
   input  logic [TAG_W-1:0] comp_idx,
   input  result_t          comp_res,
   input  logic             retire_we,
   input  logic [TAG_W-1:0] head_idx,
   output rob_entry_t       head_entry
);

   rob_state_t  state [DEPTH];
   logic [4:0]  dest  [DEPTH];
   logic [31:0] data  [DEPTH];
   logic        mp    [DEPTH];

   // Only entry state is reset; payload fields are qualified by state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) state[i] <= EMPTY;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) state[i] <= EMPTY;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (retire_we && head_idx == TAG_W'(i))
               state[i] <= EMPTY;
            else if (alloc_we && alloc_idx == TAG_W'(i))
               state[i] <= WAITING;
            else if (comp_we && comp_idx == TAG_W'(i) && state[i] == WAITING)
               state[i] <= DONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (alloc_we)
         dest[alloc_idx] <= alloc_dest;
      if (comp_we && state[comp_idx] == WAITING) begin
         data[comp_idx] <= comp_res.data;
         mp[comp_idx]   <= comp_res.mispredict;
      end
   end

   assign head_entry.state      = state[head_idx];
   assign head_entry.dest       = dest[head_idx];
   assign head_entry.data       = data[head_idx];
   assign head_entry.mispredict = mp[head_idx];

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by tag, retire at head,
// squash all younger entries when a mispredicted branch retires.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flash,
   input  logic             alloc_en,
   input  alloc_req_t       alloc_msg,
   output logic             alloc_reject,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             complete_info_en,
   input  logic [TAG_W-1:0] complete_info_tag,
   input  result_t          complete_info_msg,
   output logic             complete_info_reject,
   output logic             commit_en,
   output commit_t          commit_msg,
   input  logic             commit_reject,
   output logic             mispredict_flash
);

   localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

   logic [TAG_W:0] head, tail;
   logic           empty, full;
   logic           alloc_fire, commit_fire, mp_retire, clear;
   rob_entry_t     head_entry;
   logic           unused_is_branch;

   assign unused_is_branch = alloc_msg.is_branch;

   assign empty = (head == tail);
   assign full  = (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);

   assign alloc_reject         = full;
   assign alloc_tag            = tail[TAG_W-1:0];
   assign complete_info_reject = 1'b0;

   assign commit_en       = !empty && (head_entry.state == DONE);
   assign commit_msg.dest = head_entry.dest;
   assign commit_msg.data = head_entry.data;

   // flash suppresses every transfer in its cycle.
   assign commit_fire = commit_en && !commit_reject && !flash;
   assign alloc_fire  = alloc_en && !full && !flash;
   assign mp_retire   = commit_fire && head_entry.mispredict;
   assign clear       = flash || mp_retire;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head             <= '0;
         tail             <= '0;
         mispredict_flash <= 1'b0;
      end else begin
         mispredict_flash <= mp_retire;
         if (commit_fire)
            head <= head + PTR_ONE;
         if (flash)
            tail <= head;
         else if (mp_retire)
            tail <= head + PTR_ONE;
         else if (alloc_fire)
            tail <= tail + PTR_ONE;
      end
   end

   rob_storage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_storage (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .alloc_we   (alloc_fire),
      .alloc_idx  (tail[TAG_W-1:0]),
      .alloc_dest (alloc_msg.dest),
      .comp_we    (complete_info_en && !flash),
      .comp_idx   (complete_info_tag),
      .comp_res   (complete_info_msg),
      .retire_we  (commit_fire),
      .head_idx   (head[TAG_W-1:0]),
      .head_entry (head_entry)
   );

endmodule
